// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the unified-memory bus arbiter.
//   - Arbiter FSM state encoding (ARB_IDLE, ARB_ACCESS, ARB_RESP)
//   - Access owner encoding (OWN_I = fetch, OWN_D = data)
//   - Default address/data widths
package mem_bus_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_DATA_W = 32;

  typedef logic [1:0] arbState_t;

  localparam arbState_t ARB_IDLE   = 2'd0;
  localparam arbState_t ARB_ACCESS = 2'd1;
  localparam arbState_t ARB_RESP   = 2'd2;

  typedef logic owner_t;

  localparam owner_t OWN_I = 1'b0;
  localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: grant selection between fetch (I) and data (D) requesters.
// Data wins by default; once fetch has lost STARVE_MAX consecutive conflicts it
// wins the next one. Holds the saturating starvation counter.
// Ports:
//   clk, rst          clock, async active-low reset
//   arbEn             arbitration allowed this cycle (arbiter idle)
//   iReq, dReq        fetch / data requests
//   grantValid        a grant is issued this cycle
//   grantOwner        owner of the grant (OWN_I / OWN_D)
module arb_prio_sel
  import mem_bus_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arbEn,
  input  logic   iReq,
  input  logic   dReq,
  output logic   grantValid,
  output owner_t grantOwner
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  logic [StarveW-1:0] starveQ;
  logic               starveHit;

  assign starveHit = (starveQ == StarveW'(STARVE_MAX));

  always_comb begin
    grantValid = arbEn & (iReq | dReq);
    grantOwner = (dReq && !(iReq && starveHit)) ? OWN_D : OWN_I;
  end

  // Only a D grant that beats a pending fetch counts as a lost arbitration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starveQ <= '0;
    end else if (grantValid) begin
      if (grantOwner == OWN_I) begin
        starveQ <= '0;
      end else if (iReq && !starveHit) begin
        starveQ <= starveQ + StarveW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between instruction fetch (I)
// and the MEM-stage data port (D). Each access: IDLE (arbitrate) -> ACCESS
// (m_ce held WAIT_CYC cycles) -> RESP (one-cycle ack) -> IDLE.
// Optional macro ARB_PERF_CNT_EN adds perf_igrant/perf_dgrant/perf_conflict.
// Ports:
//   clk, rst                          clock, async active-low reset
//   i_req/i_addr/i_ack/i_rdata        fetch handshake
//   d_req/d_we/d_wmask/d_addr/d_wdata data handshake (request side)
//   d_ack/d_rdata                     data handshake (response side)
//   m_ce/m_we/m_wmask/m_addr/m_wdata  memory command, m_rdata read data
//   perf_*                            grant/conflict counters (optional)
//   stall_if, stall_mem               pipeline holds while a request is open
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned WAIT_CYC   = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_ce,
  output logic              m_we,
  output logic [3:0]        m_wmask,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       perf_igrant,
  output logic [31:0]       perf_dgrant,
  output logic [31:0]       perf_conflict,
`endif
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned WaitW = $clog2(WAIT_CYC + 1);

  arbState_t        stateQ;
  logic [WaitW-1:0] waitCntQ;
  owner_t           ownerQ;
  logic             arbEn;
  logic             lastWait;
  logic             grantValid;
  owner_t           grantOwner;

  assign arbEn    = (stateQ == ARB_IDLE);
  assign lastWait = (waitCntQ == WaitW'(WAIT_CYC - 1));

  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .clk        (clk),
    .rst        (rst),
    .arbEn      (arbEn),
    .iReq       (i_req),
    .dReq       (d_req),
    .grantValid (grantValid),
    .grantOwner (grantOwner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= ARB_IDLE;
      waitCntQ <= '0;
      ownerQ   <= OWN_I;
      m_ce     <= 1'b0;
      m_we     <= 1'b0;
      m_wmask  <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      case (stateQ)
        ARB_IDLE: begin
          if (grantValid) begin
            ownerQ   <= grantOwner;
            waitCntQ <= '0;
            m_ce     <= 1'b1;
            stateQ   <= ARB_ACCESS;
            if (grantOwner == OWN_D) begin
              m_we    <= d_we;
              m_wmask <= d_we ? d_wmask : 4'b0000;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_we    <= 1'b0;
              m_wmask <= 4'b0000;
              m_addr  <= i_addr;
              m_wdata <= '0;
            end
          end
        end
        ARB_ACCESS: begin
          if (lastWait) begin
            m_ce   <= 1'b0;
            m_we   <= 1'b0;
            stateQ <= ARB_RESP;
            if (ownerQ == OWN_I) begin
              i_rdata <= m_rdata;
              i_ack   <= 1'b1;
            end else begin
              // Writes leave the last load value in place.
              if (!m_we) d_rdata <= m_rdata;
              d_ack <= 1'b1;
            end
          end else begin
            waitCntQ <= waitCntQ + WaitW'(1);
          end
        end
        ARB_RESP: begin
          i_ack  <= 1'b0;
          d_ack  <= 1'b0;
          stateQ <= ARB_IDLE;
        end
        default: stateQ <= ARB_IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_igrant   <= '0;
      perf_dgrant   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grantValid && grantOwner == OWN_I) perf_igrant <= perf_igrant + 32'd1;
      if (grantValid && grantOwner == OWN_D) perf_dgrant <= perf_dgrant + 32'd1;
      if (arbEn && i_req && d_req) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates one single-port unified memory between the IFU instruction fetch port and the MEM-stage data port. Each side uses a req/ack handshake. The block sequences a fixed-latency memory access and returns the read data. It also drives per-side stall signals so the pipeline holds while its request is pending. Data requests have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, address width for both requesters and the memory.
DATA_W, 32, data width.
WAIT_CYC, 2, cycles m_ce is held per access (legal range ≥1).
STARVE_MAX, 4, consecutive lost arbitrations after which fetch wins over data.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address
i_ack  out  1  one-cycle pulse: fetch done, i_rdata valid
i_rdata  out  DATA_W  fetched word
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_wmask  in  4  byte write mask
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse: data access done
d_rdata  out  DATA_W  load data
m_ce  out  1  memory enable
m_we  out  1  memory write enable
m_wmask  out  4  memory byte mask
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid in the last m_ce cycle
stall_if  out  1  i_req & ~i_ack (combinational)
stall_mem  out  1  d_req & ~d_ack (combinational)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wait counter=0; starve counter=0.
  - m_ce, m_we, m_wmask, m_addr, m_wdata, i_ack, d_ack, i_rdata and d_rdata all =0.
  - Any in-flight access is dropped without an ack.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, arbitration:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both requests: grant D, unless starve==STARVE_MAX, in which case grant I.
  - On grant, register owner, address, we, wmask and wdata into the m_* outputs. Set m_ce=1 from the next cycle. Go to ACCESS.
- ACCESS:
  - m_* held stable for exactly WAIT_CYC cycles; wait counter width is $clog2(WAIT_CYC+1).
  - On the last cycle, capture m_rdata into the owner's rdata register (reads only). Deassert m_ce/m_we. Go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle. The other side's ack stays 0.
  - Return to IDLE. No arbitration happens in RESP, so a requester dropping req after seeing ack never causes a duplicate grant.
- Latency from grant to ack: WAIT_CYC+1 cycles. Back-to-back period: WAIT_CYC+2 cycles.
- Write: d_ack is issued the same way. d_rdata is not updated (keeps its last value).
- rdata registers hold their value until the next completed read on that side.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each IDLE grant to D while i_req=1.
  - Clears on every grant to I.
- A req deasserted mid-access is ignored; the access completes and ack still pulses.
- m_wmask is forced to 0 for I accesses and for D reads.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds outputs perf_igrant, perf_dgrant and perf_conflict, each 32 bits, wrap-around.
  - perf_igrant and perf_dgrant count grants per side.
  - perf_conflict counts IDLE cycles with both requests high.
  - All three reset to 0.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package mem_bus_pkg:
  - state enum (ARB_IDLE, ARB_ACCESS, ARB_RESP);
  - owner encoding (OWN_I=0, OWN_D=1);
  - default ADDR_W/DATA_W constants.
- One natural sub-module, arb_prio_sel: combinational priority/starvation grant logic plus the saturating starve counter.

Test Plan:
- Reset: hold rst=0 3 cycles then release -> all outputs 0 and stall_if/stall_mem follow req only. Assert rst=0 mid-ACCESS -> m_ce=0 immediately and no ack ever issued.
- Single fetch, WAIT_CYC=2: i_req=1, i_addr=0x0000_0040, m_rdata=0x2408_0005 -> m_ce high 2 cycles, i_ack at grant+3, i_rdata=0x2408_0005, stall_if low after ack.
- Data write: d_we=1, d_addr=0x100, d_wmask=4'b0011, d_wdata=0xDEAD_BEEF -> m_we=1 and m_wmask=0011 for 2 cycles, d_ack once, d_rdata unchanged.
- Simultaneous: i_req and d_req together, D load from 0x200 returns 0x1234 -> D granted first. I granted in the following IDLE; i_ack follows d_ack by WAIT_CYC+2 cycles.
- Starvation, STARVE_MAX=4: d_req held high continuously with i_req high -> 4 D grants, then 5th grant to I, then starve counter=0 and D resumes.
- Perf counters (ARB_PERF_CNT_EN defined): run the starvation scenario -> perf_dgrant=4, perf_igrant=1, perf_conflict=5.
